// File: rtl/serv_immenc_pkg.sv
// Shared types and constants for the bit-serial immediate encoder.
// Optional range check is enabled by defining SERV_IMMENC_RANGE_CHECK_EN.
package serv_immenc_pkg;

   typedef enum logic [2:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   // True when the bits selected by mask are all ones or all zeros (sign-extension holds).
   function automatic logic upper_fits(input logic [31:0] imm, input logic [31:0] mask);
      return ((imm & mask) == mask) || ((imm & mask) == '0);
   endfunction

endpackage

// File: rtl/serv_immenc_if.sv
// Handshake and field bus of the bit-serial immediate encoder.
interface serv_immenc_if;

   logic        i_start;
   logic [2:0]  i_fmt;
   logic [6:0]  i_opcode;
   logic [2:0]  i_funct3;
   logic [4:0]  i_rd;
   logic [4:0]  i_rs1;
   logic [4:0]  i_rs2;
   logic        i_imm;
   logic        i_imm_en;
   logic        o_busy;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_insn;
   logic        o_err;

   modport slave (
      input  i_start, i_fmt, i_opcode, i_funct3, i_rd, i_rs1, i_rs2,
      input  i_imm, i_imm_en, i_ready,
      output o_busy, o_valid, o_insn, o_err
   );

   modport master (
      output i_start, i_fmt, i_opcode, i_funct3, i_rd, i_rs1, i_rs2,
      output i_imm, i_imm_en, i_ready,
      input  o_busy, o_valid, o_insn, o_err
   );

endinterface

// File: rtl/serv_immenc_pack.sv
// Combinational scatter of a 32-bit immediate into an RV32I instruction word.
// Range check present only when SERV_IMMENC_RANGE_CHECK_EN is defined.
module serv_immenc_pack
   import serv_immenc_pkg::*;
(
   input  logic [31:0] i_imm,
   input  logic [2:0]  i_fmt,
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_funct3,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   output logic [31:0] o_insn,
   output logic        o_err
);

   always_comb begin
      o_insn = '0;
      case (i_fmt)
         FMT_S:   o_insn = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
         FMT_B:   o_insn = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:1], i_imm[11], i_opcode};
         FMT_U:   o_insn = {i_imm[31:12], i_rd, i_opcode};
         FMT_J:   o_insn = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
         // I-type and the illegal codes share the I layout
         default: o_insn = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      endcase
   end

`ifdef SERV_IMMENC_RANGE_CHECK_EN
   always_comb begin
      o_err = 1'b1;
      case (i_fmt)
         FMT_I, FMT_S: o_err = !upper_fits(i_imm, 32'hFFFF_F800);
         FMT_B:        o_err = !upper_fits(i_imm, 32'hFFFF_F000) || i_imm[0];
         FMT_U:        o_err = |i_imm[11:0];
         FMT_J:        o_err = !upper_fits(i_imm, 32'hFFF0_0000) || i_imm[0];
         default:      o_err = 1'b1;
      endcase
   end
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: rtl/serv_immenc.sv
// Bit-serial immediate encoder: collects 32 immediate bits LSB first and presents
// a parallel RV32I word with valid/ready. SERV_IMMENC_RANGE_CHECK_EN enables o_err.
module serv_immenc
   import serv_immenc_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   serv_immenc_if.slave  io_bus
);

   state_e      r_state;
   state_e      w_next;
   logic [4:0]  r_cnt;
   logic [31:0] r_imm;
   logic [2:0]  r_fmt;
   logic [6:0]  r_opcode;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic [4:0]  r_rs1;
   logic [4:0]  r_rs2;

   logic        w_accept;
   logic        w_shift;
   logic [31:0] w_insn;
   logic        w_err;

   assign w_accept = io_bus.i_start &&
                     ((r_state == ST_IDLE) || ((r_state == ST_DONE) && io_bus.i_ready));
   assign w_shift  = (r_state == ST_SHIFT) && io_bus.i_imm_en;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (io_bus.i_start) w_next = ST_SHIFT;
         ST_SHIFT: if (w_shift && (r_cnt == 5'd31)) w_next = ST_DONE;
         ST_DONE:  if (io_bus.i_ready) w_next = io_bus.i_start ? ST_SHIFT : ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_imm    <= '0;
         r_fmt    <= '0;
         r_opcode <= '0;
         r_funct3 <= '0;
         r_rd     <= '0;
         r_rs1    <= '0;
         r_rs2    <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_fmt    <= io_bus.i_fmt;
         r_opcode <= io_bus.i_opcode;
         r_funct3 <= io_bus.i_funct3;
         r_rd     <= io_bus.i_rd;
         r_rs1    <= io_bus.i_rs1;
         r_rs2    <= io_bus.i_rs2;
      end else if (w_shift) begin
         // LSB arrives first, so after 32 right shifts bit 0 holds imm[0]
         r_imm <= {io_bus.i_imm, r_imm[31:1]};
         r_cnt <= r_cnt + 5'd1;
      end
   end

   serv_immenc_pack u_pack (
      .i_imm    (r_imm),
      .i_fmt    (r_fmt),
      .i_opcode (r_opcode),
      .i_funct3 (r_funct3),
      .i_rd     (r_rd),
      .i_rs1    (r_rs1),
      .i_rs2    (r_rs2),
      .o_insn   (w_insn),
      .o_err    (w_err)
   );

   assign io_bus.o_busy  = (r_state == ST_SHIFT);
   assign io_bus.o_valid = (r_state == ST_DONE);
   assign io_bus.o_insn  = (r_state == ST_DONE) ? w_insn : '0;
   assign io_bus.o_err   = (r_state == ST_DONE) ? w_err  : 1'b0;

endmodule
